led_status_engine: RTL

LED_STATUS_ENGINE -- requirements
Module: led_status_engine

---
 rtl/led_status_engine.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/led_status_engine.sv
`default_nettype none
//==============================================================================
// Module   : led_status_engine
// Desc     : Registered LED strip driver: health bars with hit flash, win chase
//            and draw/illegal blink selected from the game state.
// Revision : 1.0 - initial release
//==============================================================================
module led_status_engine #(
    parameter int NUM_LEDS      = 10,
    parameter int MAX_HEALTH    = 3,
    parameter int BLINK_HALF    = 25000000,
    parameter int FLASH_HALF    = 2500000,
    parameter int FLASH_TOGGLES = 6,
    parameter int CHASE_STEP    = 5000000,
    localparam int HW           = $clog2(MAX_HEALTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          game_state,
    input  logic [HW-1:0]       p1_health,
    input  logic [HW-1:0]       p2_health,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int c_pos_w   = (NUM_LEDS   > 1) ? $clog2(NUM_LEDS)   : 1;
    localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int c_flash_w = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int c_chase_w = (CHASE_STEP > 1) ? $clog2(CHASE_STEP) : 1;
    localparam int c_tog_w   = $clog2(FLASH_TOGGLES + 1);

    localparam logic [c_pos_w-1:0]    c_pos_top    = c_pos_w'(NUM_LEDS - 1);
    localparam logic [c_blink_w-1:0]  c_blink_last = c_blink_w'(BLINK_HALF - 1);
    localparam logic [c_flash_w-1:0]  c_flash_last = c_flash_w'(FLASH_HALF - 1);
    localparam logic [c_chase_w-1:0]  c_chase_last = c_chase_w'(CHASE_STEP - 1);
    localparam logic [c_tog_w-1:0]    c_tog_load   = c_tog_w'(FLASH_TOGGLES);
    localparam logic [c_tog_w-1:0]    c_tog_one    = c_tog_w'(1);
    localparam logic [HW-1:0]         c_max_h      = HW'(MAX_HEALTH);
    localparam logic [MAX_HEALTH-1:0] c_bar_full   = '1;
    localparam logic [NUM_LEDS-1:0]   c_led_one    = NUM_LEDS'(1);

    typedef enum logic [2:0] {
        MODE_OFF        = 3'd0,
        MODE_HEALTH     = 3'd1,
        MODE_CHASE_DOWN = 3'd2,
        MODE_CHASE_UP   = 3'd3,
        MODE_BLINK      = 3'd4
    } mode_t;

    mode_t                 r_mode, w_mode;
    logic                  w_entry;
    logic                  w_health_mode;
    logic [c_pos_w-1:0]    r_pos, w_pos_n;
    logic [c_chase_w-1:0]  r_chase_cnt, w_chase_cnt_n;
    logic [c_blink_w-1:0]  r_blink_cnt, w_blink_cnt_n;
    logic                  r_blink_on, w_blink_on_n;
    logic [NUM_LEDS-1:0]   w_leds_n;

    always_comb begin
        w_mode = MODE_BLINK;
        case (game_state)
            3'd0:       w_mode = MODE_OFF;
            3'd1, 3'd2: w_mode = MODE_HEALTH;
            3'd3:       w_mode = MODE_CHASE_DOWN;
            3'd4:       w_mode = MODE_CHASE_UP;
            default:    w_mode = MODE_BLINK;
        endcase
    end

    assign w_entry       = (w_mode != r_mode);
    assign w_health_mode = (w_mode == MODE_HEALTH);

    // Per-player saturation, hit detection and flash timing
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic [HW-1:0]         w_raw;
        logic [HW-1:0]         w_sat;
        logic                  w_hit;
        logic [HW-1:0]         r_prev;
        logic                  r_active, w_active_n;
        logic [c_flash_w-1:0]  r_cnt, w_cnt_n;
        logic [c_tog_w-1:0]    r_tog, w_tog_n;
        logic [MAX_HEALTH-1:0] w_bar;

        assign w_raw = (gi == 0) ? p1_health : p2_health;
        assign w_sat = (w_raw > c_max_h) ? c_max_h : w_raw;
        assign w_hit = w_health_mode && (w_sat < r_prev);

        always_comb begin
            w_active_n = r_active;
            w_cnt_n    = r_cnt;
            w_tog_n    = r_tog;
            if (!w_health_mode) begin
                w_active_n = 1'b0;
                w_cnt_n    = '0;
                w_tog_n    = '0;
            end else if (w_hit) begin
                w_active_n = 1'b1;
                w_cnt_n    = '0;
                w_tog_n    = c_tog_load;
            end else if (r_active) begin
                if (r_cnt == c_flash_last) begin
                    w_cnt_n    = '0;
                    w_tog_n    = r_tog - 1'b1;
                    w_active_n = (r_tog != c_tog_one);
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            // Even toggle count remaining marks the dark half-period
            w_bar = ~(c_bar_full >> w_sat);
            if (w_active_n && !w_tog_n[0]) begin
                w_bar = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_prev   <= c_max_h;
                r_active <= 1'b0;
                r_cnt    <= '0;
                r_tog    <= '0;
            end else begin
                r_prev   <= w_sat;
                r_active <= w_active_n;
                r_cnt    <= w_cnt_n;
                r_tog    <= w_tog_n;
            end
        end
    end

    always_comb begin
        w_pos_n       = r_pos;
        w_chase_cnt_n = r_chase_cnt;
        w_blink_cnt_n = r_blink_cnt;
        w_blink_on_n  = r_blink_on;
        if (w_entry) begin
            w_pos_n       = (w_mode == MODE_CHASE_DOWN) ? c_pos_top : '0;
            w_chase_cnt_n = '0;
            w_blink_cnt_n = '0;
            w_blink_on_n  = 1'b1;
        end else begin
            case (w_mode)
                MODE_CHASE_DOWN: begin
                    if (r_chase_cnt == c_chase_last) begin
                        w_chase_cnt_n = '0;
                        w_pos_n       = (r_pos == '0) ? c_pos_top : r_pos - 1'b1;
                    end else begin
                        w_chase_cnt_n = r_chase_cnt + 1'b1;
                    end
                end
                MODE_CHASE_UP: begin
                    if (r_chase_cnt == c_chase_last) begin
                        w_chase_cnt_n = '0;
                        w_pos_n       = (r_pos == c_pos_top) ? '0 : r_pos + 1'b1;
                    end else begin
                        w_chase_cnt_n = r_chase_cnt + 1'b1;
                    end
                end
                MODE_BLINK: begin
                    if (r_blink_cnt == c_blink_last) begin
                        w_blink_cnt_n = '0;
                        w_blink_on_n  = ~r_blink_on;
                    end else begin
                        w_blink_cnt_n = r_blink_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        w_leds_n = '0;
        case (w_mode)
            MODE_HEALTH: begin
                w_leds_n[NUM_LEDS-1 -: MAX_HEALTH] = g_player[0].w_bar;
                w_leds_n[MAX_HEALTH-1:0]           = g_player[1].w_bar;
            end
            MODE_CHASE_DOWN, MODE_CHASE_UP: w_leds_n = c_led_one << w_pos_n;
            MODE_BLINK:                     w_leds_n = {NUM_LEDS{w_blink_on_n}};
            default:                        w_leds_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_OFF;
            r_pos       <= '0;
            r_chase_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            leds        <= '0;
        end else begin
            r_mode      <= w_mode;
            r_pos       <= w_pos_n;
            r_chase_cnt <= w_chase_cnt_n;
            r_blink_cnt <= w_blink_cnt_n;
            r_blink_on  <= w_blink_on_n;
            leds        <= w_leds_n;
        end
    end

endmodule
`default_nettype wire
